// File: rtl/wb_pkg.sv
// Shared encodings for the writeback stage: source selects, load sizes, FSM states.
package wb_pkg;

  localparam logic [1:0] WB_SEL_ALU  = 2'b00;
  localparam logic [1:0] WB_SEL_MEM  = 2'b01;
  localparam logic [1:0] WB_SEL_LINK = 2'b10;
  localparam logic [1:0] WB_SEL_IMM  = 2'b11;

  localparam logic [1:0] LD_BYTE  = 2'b00;
  localparam logic [1:0] LD_HALF  = 2'b01;
  localparam logic [1:0] LD_WORD  = 2'b10;
  localparam logic [1:0] LD_DWORD = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/wb_stage_pipe_load_formatter.sv
// Combinational load formatter: little-endian extract, zero/sign extend, alignment check.
module load_formatter
  import wb_pkg::*;
#(
  parameter int DATA_W = 32,
  localparam int OFF_W = $clog2(DATA_W / 8)
) (
  input  logic [DATA_W-1:0] rdata,
  input  logic [OFF_W-1:0]  off,
  input  logic [1:0]        ld_size,
  input  logic              ld_unsigned,
  output logic [DATA_W-1:0] data,
  output logic              misalign
);

  logic [DATA_W-1:0] shifted;
  logic              msb;
  int                top;

  // Shift the addressed byte down to bit 0, then extend above the field's top bit.
  always_comb begin
    shifted  = rdata >> {off, 3'b000};
    top      = DATA_W - 1;
    msb      = shifted[DATA_W-1];
    misalign = 1'b0;
    data     = '0;
    case (ld_size)
      LD_BYTE: begin
        top = 7;
        msb = shifted[7];
      end
      LD_HALF: begin
        top      = 15;
        msb      = shifted[15];
        misalign = off[0];
      end
      LD_WORD: begin
        top      = 31;
        msb      = shifted[31];
        misalign = (off[1:0] != 2'b00);
      end
      default: begin
        // A dword only exists on a 64-bit datapath and must be fully aligned.
        misalign = (DATA_W != 64) || (off != '0);
      end
    endcase
    for (int i = 0; i < DATA_W; i++) begin
      data[i] = (i <= top) ? shifted[i] : (msb & ~ld_unsigned);
    end
  end

endmodule

// File: rtl/wb_stage_pipe.sv
// Writeback stage with MEM/WB register, variable-latency load wait, and sticky error flags.
module wb_stage_pipe
  import wb_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int REG_ADDR_W  = 5,
  parameter int TIMEOUT     = 255,
  parameter int ZERO_REG_HW = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     alu_result,
  input  logic [DATA_W-1:0]     link_pc,
  input  logic [DATA_W-1:0]     imm_val,
  input  logic [REG_ADDR_W-1:0] write_reg,
  input  logic                  reg_write,
  input  logic [1:0]            wb_sel,
  input  logic [1:0]            ld_size,
  input  logic                  ld_unsigned,
  input  logic                  mem_rvalid,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic                  err_clr,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0]     rf_wdata,
  output logic                  err_misalign,
  output logic                  err_timeout,
  output logic                  err_spurious
);

  localparam int          OFF_W    = $clog2(DATA_W / 8);
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_t                  state_reg;
  logic [15:0]             cnt_reg;
  logic [REG_ADDR_W-1:0]   waddr_reg;
  logic                    reg_write_reg;
  logic [1:0]              size_reg;
  logic                    unsigned_reg;
  logic [OFF_W-1:0]        off_reg;

  logic                    accept;
  logic                    is_load;
  logic                    idle;
  logic [OFF_W-1:0]        fmt_off;
  logic [1:0]              fmt_size;
  logic                    fmt_unsigned;
  logic [DATA_W-1:0]       fmt_data;
  logic                    fmt_mis;
  logic                    do_write;
  logic [REG_ADDR_W-1:0]   wr_addr;
  logic [DATA_W-1:0]       wr_data;
  logic                    timeout_hit;

  function automatic logic dest_ok(input logic [REG_ADDR_W-1:0] a, input logic rw);
    return rw && !((ZERO_REG_HW != 0) && (a == '0));
  endfunction

  assign idle        = (state_reg == IDLE);
  assign in_ready    = idle;
  assign accept      = in_valid && idle;
  assign is_load     = (wb_sel == WB_SEL_MEM);
  assign timeout_hit = !idle && !mem_rvalid && (cnt_reg == CNT_LAST);

  // In IDLE the formatter sees the live instruction; in WAIT it sees the captured load.
  assign fmt_off      = idle ? alu_result[OFF_W-1:0] : off_reg;
  assign fmt_size     = idle ? ld_size : size_reg;
  assign fmt_unsigned = idle ? ld_unsigned : unsigned_reg;

  load_formatter #(.DATA_W(DATA_W)) u_fmt (
    .rdata       (mem_rdata),
    .off         (fmt_off),
    .ld_size     (fmt_size),
    .ld_unsigned (fmt_unsigned),
    .data        (fmt_data),
    .misalign    (fmt_mis)
  );

  // Decide whether this edge produces a register-file write, and with what.
  always_comb begin
    do_write = 1'b0;
    wr_addr  = write_reg;
    case (wb_sel)
      WB_SEL_ALU:  wr_data = alu_result;
      WB_SEL_MEM:  wr_data = fmt_data;
      WB_SEL_LINK: wr_data = link_pc;
      default:     wr_data = imm_val;
    endcase
    if (idle) begin
      if (accept && (!is_load || mem_rvalid)) begin
        do_write = dest_ok(write_reg, reg_write) && !(is_load && fmt_mis);
      end
    end else if (mem_rvalid) begin
      do_write = dest_ok(waddr_reg, reg_write_reg) && !fmt_mis;
      wr_addr  = waddr_reg;
      wr_data  = fmt_data;
    end
  end

  // FSM, wait counter, MEM/WB capture and registered write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      waddr_reg     <= '0;
      reg_write_reg <= 1'b0;
      size_reg      <= LD_BYTE;
      unsigned_reg  <= 1'b0;
      off_reg       <= '0;
      rf_we         <= 1'b0;
      rf_waddr      <= '0;
      rf_wdata      <= '0;
    end else begin
      rf_we <= do_write;
      if (do_write) begin
        rf_waddr <= wr_addr;
        rf_wdata <= wr_data;
      end
      case (state_reg)
        IDLE: begin
          if (accept) begin
            waddr_reg     <= write_reg;
            reg_write_reg <= reg_write;
            size_reg      <= ld_size;
            unsigned_reg  <= ld_unsigned;
            off_reg       <= alu_result[OFF_W-1:0];
            if (is_load && !mem_rvalid) begin
              state_reg <= WAIT;
              cnt_reg   <= '0;
            end
          end
        end
        default: begin
          if (mem_rvalid || timeout_hit) begin
            state_reg <= IDLE;
          end else begin
            cnt_reg <= cnt_reg + 16'd1;
          end
        end
      endcase
    end
  end

  // Sticky error flags; a new set event beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_misalign <= 1'b0;
      err_timeout  <= 1'b0;
      err_spurious <= 1'b0;
    end else begin
      err_misalign <= (accept && is_load && fmt_mis) | (err_misalign & ~err_clr);
      err_timeout  <= timeout_hit | (err_timeout & ~err_clr);
      err_spurious <= (idle && mem_rvalid && !(accept && is_load)) | (err_spurious & ~err_clr);
    end
  end

endmodule
